// File: rtl/frame_int.sv
// ---------------------------------------------------------------------------
// frame_int
//
// Turns each rising edge of the video generator's frame sync (irq) into a
// Z80 maskable interrupt. The interrupt is held for at most INT_LEN CPU
// T-states, or until the CPU acknowledges it with an M1+IORQ cycle. During
// that cycle the IM2 vector byte is offered on vec_data. The block also
// counts frames and keeps a sticky flag for frame edges that arrive while an
// interrupt is still being serviced.
//
// Ports
//   clock     in   system clock (25 MHz)
//   reset_n   in   asynchronous active-low reset
//   irq       in   frame sync level, asynchronous to clock
//   cpu_ce    in   one-clock pulse per CPU T-state
//   m1_n      in   Z80 /M1
//   iorq_n    in   Z80 /IORQ
//   int_en    in   1 = interrupts allowed, 0 = masked (frames still counted)
//   miss_clr  in   one-clock pulse, clears missed
//   int_n     out  Z80 /INT, active low
//   int_ack   out  one-clock pulse when an acknowledge is accepted
//   vec_oe    out  high while vec_data must drive the CPU data bus
//   vec_data  out  IM2 vector byte (constant VECTOR)
//   frames    out  count of detected frame edges, wraps at 16 bits
//   missed    out  sticky: frame edge seen while an interrupt was in progress
// ---------------------------------------------------------------------------
module frame_int #(
  parameter int         INT_LEN = 32,
  parameter logic [7:0] VECTOR  = 8'hFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        irq,
  input  logic        cpu_ce,
  input  logic        m1_n,
  input  logic        iorq_n,
  input  logic        int_en,
  input  logic        miss_clr,
  output logic        int_n,
  output logic        int_ack,
  output logic        vec_oe,
  output logic [7:0]  vec_data,
  output logic [15:0] frames,
  output logic        missed
);

  localparam int CNT_W = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_T = CNT_W'(INT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_ACK_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_int_n;
  logic             r_int_ack;
  logic [15:0]      r_frames;
  logic             r_missed;

  logic             w_event;
  logic             w_ack;
  logic             w_busy;

  // Stage 1: synchronized irq rising edge and Z80 acknowledge decode
  assign w_event = r_s2 & ~r_prev;
  assign w_ack   = ~m1_n & ~iorq_n;
  assign w_busy  = (r_state != S_IDLE);

  // Synchronizer and history flops reset high so an irq already high when
  // reset releases does not look like a fresh frame edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_prev    <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_int_n   <= 1'b1;
      r_int_ack <= 1'b0;
      r_frames  <= 16'd0;
      r_missed  <= 1'b0;
    end else begin
      r_s1      <= irq;
      r_s2      <= r_s1;
      r_prev    <= r_s2;
      r_int_ack <= 1'b0;

      if (w_event) begin
        r_frames <= r_frames + 16'd1;
      end

      // A new edge while busy is flagged, and a simultaneous clear loses.
      if (w_event && w_busy) begin
        r_missed <= 1'b1;
      end else if (miss_clr) begin
        r_missed <= 1'b0;
      end

      // Stage 2: interrupt sequencing
      case (r_state)
        S_IDLE: begin
          if (w_event && int_en) begin
            r_state <= S_ASSERT;
            r_int_n <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_ASSERT: begin
          // Acknowledge outranks the T-state timeout on the same clock.
          if (w_ack) begin
            r_int_n   <= 1'b1;
            r_int_ack <= 1'b1;
            r_state   <= S_ACK_WAIT;
          end else if (cpu_ce && (r_cnt == LAST_T)) begin
            r_int_n <= 1'b1;
            r_state <= S_IDLE;
          end else if (cpu_ce) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ACK_WAIT: begin
          // Hold here for the rest of a long acknowledge so it yields one pulse.
          if (!w_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_int_n <= 1'b1;
        end
      endcase
    end
  end

  // Stage 3: outputs; the vector is offered from the detecting clock onward
  assign vec_oe   = w_ack & ((r_state == S_ASSERT) | (r_state == S_ACK_WAIT));
  assign vec_data = VECTOR;
  assign int_n    = r_int_n;
  assign int_ack  = r_int_ack;
  assign frames   = r_frames;
  assign missed   = r_missed;

endmodule

// File: tb/tb_frame_int.sv
// ---------------------------------------------------------------------------
// tb_frame_int
//
// Bench for frame_int. A behavioural model (edge history, "interrupt low with
// N T-states left", "acknowledge in progress") is stepped on every rising
// clock edge and compared with the DUT on the falling edge. Directed
// sequences cover latency, timeout, acknowledge, masking, counter wrap,
// missed-flag priority and asynchronous reset; a scenario table and a random
// phase follow.
// ---------------------------------------------------------------------------
module tb_frame_int;

  localparam int         INT_LEN = 32;
  localparam logic [7:0] VEC     = 8'hFF;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        irq;
  logic        cpu_ce;
  logic        m1_n;
  logic        iorq_n;
  logic        int_en;
  logic        miss_clr;
  logic        int_n;
  logic        int_ack;
  logic        vec_oe;
  logic [7:0]  vec_data;
  logic [15:0] frames;
  logic        missed;

  always #20 clock = ~clock;

  frame_int #(.INT_LEN(INT_LEN), .VECTOR(VEC)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .irq      (irq),
    .cpu_ce   (cpu_ce),
    .m1_n     (m1_n),
    .iorq_n   (iorq_n),
    .int_en   (int_en),
    .miss_clr (miss_clr),
    .int_n    (int_n),
    .int_ack  (int_ack),
    .vec_oe   (vec_oe),
    .vec_data (vec_data),
    .frames   (frames),
    .missed   (missed)
  );

  int   n_chk      = 0;
  int   n_pass     = 0;
  int   n_falls    = 0;
  int   n_acks     = 0;
  int   ce_k       = 0;
  logic last_int_n = 1'b1;

  // Reference model state
  logic [2:0]  m_hist;
  logic        m_low;
  logic        m_inack;
  logic        m_ack;
  int          m_left;
  logic [15:0] m_frames;
  logic        m_missed;

  typedef struct {
    logic en;
    int   edges;
    int   gap;
    int   ce_per;
    int   exp_frames;
    int   exp_ints;
    logic exp_missed;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_hist   = 3'b111;
    m_low    = 1'b0;
    m_inack  = 1'b0;
    m_ack    = 1'b0;
    m_left   = 0;
    m_frames = 16'd0;
    m_missed = 1'b0;
  endtask

  task automatic model_update();
    logic ev;
    logic ack;
    logic busy;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ev     = m_hist[1] & ~m_hist[2];
    m_hist = {m_hist[1:0], irq};
    ack    = !m1_n && !iorq_n;
    busy   = m_low || m_inack;
    m_ack  = 1'b0;
    if (ev) m_frames = m_frames + 16'd1;
    if (ev && busy) m_missed = 1'b1;
    else if (miss_clr) m_missed = 1'b0;
    if (m_low) begin
      if (ack) begin
        m_low   = 1'b0;
        m_inack = 1'b1;
        m_ack   = 1'b1;
      end else if (cpu_ce) begin
        m_left = m_left - 1;
        if (m_left == 0) m_low = 1'b0;
      end
    end else if (m_inack) begin
      if (!ack) m_inack = 1'b0;
    end else if (ev && int_en) begin
      m_low  = 1'b1;
      m_left = INT_LEN;
    end
  endtask

  task automatic step();
    logic e_vec;
    @(posedge clock);
    model_update();
    @(negedge clock);
    if (int_ack) n_acks++;
    if (last_int_n && !int_n) n_falls++;
    last_int_n = int_n;
    e_vec = (!m1_n && !iorq_n) && (m_low || m_inack);
    chk("mdl_int_n", int_n, !m_low);
    chk("mdl_int_ack", int_ack, m_ack);
    chk("mdl_vec_oe", vec_oe, e_vec);
    chk("mdl_vec_data", vec_data, VEC);
    chk("mdl_frames", frames, m_frames);
    chk("mdl_missed", missed, m_missed);
  endtask

  task automatic tick_ce(input int per);
    cpu_ce = ((ce_k % per) == 0);
    ce_k++;
    step();
  endtask

  initial begin
    int   p;
    int   k;
    int   a0;
    int   f0;
    logic ack_on;

    tbl[0] = '{1'b0, 3, 40, 7, 3, 0, 1'b0};
    tbl[1] = '{1'b1, 2, 80, 1, 2, 2, 1'b0};
    tbl[2] = '{1'b1, 2, 80, 7, 2, 1, 1'b1};
    tbl[3] = '{1'b1, 3, 40, 1, 3, 3, 1'b0};
    tbl[4] = '{1'b1, 2, 20, 1, 2, 1, 1'b1};

    reset_n = 1'b0; irq = 1'b0; cpu_ce = 1'b0; m1_n = 1'b1; iorq_n = 1'b1;
    int_en = 1'b1; miss_clr = 1'b0;
    model_reset();
    step(); step();
    chk("rst_int_n", int_n, 1'b1);
    chk("rst_int_ack", int_ack, 1'b0);
    chk("rst_vec_oe", vec_oe, 1'b0);
    chk("rst_frames", frames, 16'd0);
    chk("rst_missed", missed, 1'b0);
    reset_n = 1'b1;
    repeat (3) step();

    // Latency: int_n falls after the third edge that sees irq high
    irq = 1'b1;
    step(); chk("lat_e1", int_n, 1'b1);
    step(); chk("lat_e2", int_n, 1'b1);
    step(); chk("lat_e3", int_n, 1'b0);

    // Timeout with cpu_ce every 7 clocks and no acknowledge
    p = 0; a0 = n_acks;
    for (int i = 0; i < 1000; i++) begin
      cpu_ce = ((i % 7) == 0);
      if (cpu_ce && !int_n) p++;
      step();
    end
    cpu_ce = 1'b0;
    chk("to_pulses", p, INT_LEN);
    chk("to_int_n", int_n, 1'b1);
    chk("to_acks", n_acks - a0, 0);
    chk("to_frames", frames, 16'd1);

    // Acknowledge held for 12 clocks after 10 T-states
    irq = 1'b0; repeat (4) step();
    irq = 1'b1;
    k = 0;
    while (int_n && k < 10) begin step(); k++; end
    chk("ack_int_fell", int_n, 1'b0);
    p = 0; k = 0;
    while (p < 10 && k < 200) begin
      cpu_ce = ((k % 7) == 0);
      if (cpu_ce) p++;
      step(); k++;
    end
    cpu_ce = 1'b0; m1_n = 1'b0; iorq_n = 1'b0; a0 = n_acks;
    #1;
    chk("ack_vec_oe_first", vec_oe, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) begin
        chk("ack_int_n_rel", int_n, 1'b1);
        chk("ack_pulse", int_ack, 1'b1);
      end
      chk("ack_vec_oe", vec_oe, 1'b1);
      chk("ack_vec_data", vec_data, VEC);
    end
    m1_n = 1'b1; iorq_n = 1'b1;
    #1;
    chk("ack_vec_oe_off", vec_oe, 1'b0);
    step();
    chk("ack_count", n_acks - a0, 1);
    chk("ack_int_n_after", int_n, 1'b1);

    // Frame counter wrap (masked so no interrupt is left pending)
    irq = 1'b0; int_en = 1'b0; repeat (4) step();
    force dut.r_frames = 16'hFFFF;
    #1;
    release dut.r_frames;
    m_frames = 16'hFFFF;
    chk("wrap_pre", frames, 16'hFFFF);
    irq = 1'b1; repeat (3) step();
    chk("wrap", frames, 16'd0);
    chk("wrap_masked", int_n, 1'b1);

    // Missed flag: no ack, no T-states
    irq = 1'b0; int_en = 1'b1; cpu_ce = 1'b0; repeat (4) step();
    irq = 1'b1; repeat (3) step();
    chk("miss_first_int", int_n, 1'b0);
    chk("miss_pre", missed, 1'b0);
    irq = 1'b0; repeat (4) step();
    irq = 1'b1; repeat (3) step();
    chk("miss_set", missed, 1'b1);
    chk("miss_int_held", int_n, 1'b0);
    irq = 1'b0; repeat (4) step();
    irq = 1'b1; step(); step();
    miss_clr = 1'b1; step(); miss_clr = 1'b0;
    chk("miss_set_wins", missed, 1'b1);
    miss_clr = 1'b1; step(); miss_clr = 1'b0;
    chk("miss_clr", missed, 1'b0);
    f0 = n_falls; cpu_ce = 1'b1; k = 0;
    while (!int_n && k < 40) begin step(); k++; end
    chk("miss_timeout", int_n, 1'b1);
    repeat (20) step();
    cpu_ce = 1'b0;
    chk("miss_no_second", n_falls - f0, 0);

    // Asynchronous reset in the middle of an interrupt
    irq = 1'b0; repeat (4) step();
    irq = 1'b1; repeat (3) step();
    chk("arst_int_low", int_n, 1'b0);
    #5 reset_n = 1'b0;
    #1;
    chk("arst_int_n", int_n, 1'b1);
    chk("arst_int_ack", int_ack, 1'b0);
    chk("arst_frames", frames, 16'd0);
    f0 = n_falls;
    step(); step();
    reset_n = 1'b1;
    repeat (10) step();
    chk("arst_no_int", n_falls - f0, 0);
    irq = 1'b0; repeat (4) step();
    irq = 1'b1; repeat (3) step();
    chk("arst_new_int", int_n, 1'b0);
    chk("arst_frames_new", frames, 16'd1);

    // Scenario table
    for (int r = 0; r < 5; r++) begin
      irq = 1'b0; cpu_ce = 1'b0; int_en = tbl[r].en; ce_k = 0;
      reset_n = 1'b0; step(); reset_n = 1'b1; step();
      f0 = n_falls;
      for (int e = 0; e < tbl[r].edges; e++) begin
        repeat (tbl[r].gap / 2) tick_ce(tbl[r].ce_per);
        irq = 1'b1;
        repeat (tbl[r].gap / 2) tick_ce(tbl[r].ce_per);
        irq = 1'b0;
      end
      repeat (260) tick_ce(tbl[r].ce_per);
      cpu_ce = 1'b0;
      chk($sformatf("tbl%0d_frames", r), frames, tbl[r].exp_frames);
      chk($sformatf("tbl%0d_ints", r), n_falls - f0, tbl[r].exp_ints);
      chk($sformatf("tbl%0d_missed", r), missed, tbl[r].exp_missed);
    end

    // Random traffic against the model
    irq = 1'b0; int_en = 1'b1; ack_on = 1'b0;
    reset_n = 1'b0; step(); reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 24) == 0) irq = ~irq;
      cpu_ce = (($urandom % 3) == 0);
      if (($urandom % 10) == 0) ack_on = ~ack_on;
      m1_n     = ~ack_on;
      iorq_n   = ~ack_on | (($urandom % 6) == 0);
      int_en   = (($urandom % 8) != 0);
      miss_clr = (($urandom % 40) == 0);
      step();
    end
    m1_n = 1'b1; iorq_n = 1'b1; miss_clr = 1'b0; cpu_ce = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_int.md
Name: frame_int

Overview:
- Downstream consumer of the video generator's frame `irq` output.
- Turns each rising edge of that signal into a Z80 maskable interrupt (`int_n`) of bounded length, measured in CPU T-states.
- Handles the M1+IORQ acknowledge cycle and drives the IM2 vector byte during it.
- Keeps a frame counter and a sticky missed-interrupt flag for the system.

Parameters:
- INT_LEN, 32: max number of cpu_ce pulses `int_n` stays low without acknowledge.
- VECTOR, 8'hFF: byte driven on `vec_data` during the acknowledge cycle.

Ports:
- clock  in  1  25 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- irq  in  1  frame sync level from the video generator; treated as asynchronous.
- cpu_ce  in  1  one-clock pulse per CPU T-state.
- m1_n  in  1  Z80 /M1.
- iorq_n  in  1  Z80 /IORQ.
- int_en  in  1  1 = interrupts allowed; 0 = masked (frames still counted).
- miss_clr  in  1  one-clock pulse; clears `missed`.
- int_n  out  1  Z80 /INT, active low.
- int_ack  out  1  one-clock pulse when an acknowledge is accepted.
- vec_oe  out  1  high while `vec_data` must be placed on the CPU data bus.
- vec_data  out  8  constant VECTOR.
- frames  out  16  count of detected frame edges, wraps.
- missed  out  1  sticky: a frame edge arrived while an interrupt was still in progress.

Behaviour:
- Reset (async, while reset_n=0):
  - int_n=1, int_ack=0, vec_oe=0, frames=0, missed=0.
  - State IDLE, T-state counter=0.
  - Both synchronizer flops and the edge-history flop are forced to 1, so `irq` high at reset release produces no event.
- Synchronizer and edge detect:
  - `irq` passes through a 2-flop synchronizer (s1→s2); `prev` holds the previous s2.
  - event = s2 & ~prev.
- Latency: counting the first clock edge that samples irq=1 as edge 1, `int_n` falls after edge 3, provided state was IDLE and int_en=1.
- frames increments by 1 on every event, regardless of int_en or state; 16'hFFFF wraps to 0.
- State IDLE:
  - event & int_en → ASSERT; int_n←0, counter←0.
  - event & ~int_en → stay IDLE; no interrupt, no missed.
- State ASSERT, priorities in this order:
  1. Acknowledge: m1_n=0 & iorq_n=0 sampled on a clock edge → int_n←1, int_ack←1 for exactly one clock, go ACK_WAIT.
  2. Timeout: else if cpu_ce=1 and counter==INT_LEN-1 → int_n←1, go IDLE, no int_ack.
  3. Count: else if cpu_ce=1 → counter+1.
  - Net effect: without acknowledge, int_n stays low for exactly INT_LEN cpu_ce pulses sampled while int_n=0.
  - int_en falling during ASSERT does not cut the pulse short.
- State ACK_WAIT:
  - Stay while m1_n=0 & iorq_n=0; a long acknowledge cycle must yield only one int_ack.
  - When either signal goes high → IDLE.
- vec_oe (combinational) = (state==ACK_WAIT, or the ASSERT clock where the ack is detected) & ~m1_n & ~iorq_n.
  - vec_data is always VECTOR.
- missed:
  - Set on any event while state≠IDLE, including the clock where ASSERT times out or goes to ACK_WAIT. That event does not start a new interrupt.
  - Cleared by miss_clr; if set and clear occur on the same clock, set wins.
- A reset during ASSERT or ACK_WAIT releases int_n immediately (asynchronously). No int_ack is produced.

Test Plan:
- INT_LEN=32, cpu_ce every 7 clocks, no ack; raise irq for 1000 clocks → int_n low from clock 3 for exactly 32 cpu_ce pulses; int_ack never pulses; frames=1.
- Raise irq; 10 cpu_ce pulses after int_n falls, hold m1_n=iorq_n=0 for 12 clocks → one int_ack pulse; int_n high next clock; vec_oe=1 with vec_data=8'hFF for the whole ack window; vec_oe=0 after release.
- Hold int_en=0; issue 3 irq edges → int_n stays 1, frames=3, missed=0.
- Preload frames to 16'hFFFF via 65535 edges, or force in sim; one more edge → frames=0.
- CPU never acks, cpu_ce held low; second irq edge while in ASSERT → missed=1, no second interrupt after timeout. Same-clock miss_clr with another event → missed stays 1. Lone miss_clr → missed=0.
- Assert reset_n=0 mid-ASSERT → int_n=1 asynchronously. Release with irq held high → no interrupt until irq falls and rises again.
